disp_arbiter: RTL

DISP_ARBITER -- requirements
Module: disp_arbiter

---
 rtl/disp_pkg.sv | 13 +
 rtl/scan_prescaler.sv | 30 +++
 rtl/disp_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared types and constants for the display arbiter slice.
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int DIGITS = 4;
  localparam int NUM_W  = DIGITS * 4;

endpackage

// File: rtl/scan_prescaler.sv
// Free-running divider producing a one-cycle digit-scan strobe every SCAN_DIV clocks.
module scan_prescaler
  import disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  logic [23:0] r_cnt;
  logic        r_tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt == 24'(SCAN_DIV - 1)) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + 24'd1;
      r_tick <= 1'b0;
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/disp_arbiter.sv
// Round-robin owner selection for a shared 4-digit display, with a minimum
// dwell time per owner, a lock that freezes the grant, and a scan strobe.
module disp_arbiter
  import disp_pkg::*;
#(
  parameter int          N_REQ    = 4,
  parameter int unsigned DWELL    = 50_000_000,
  parameter int unsigned SCAN_DIV = 100_000,
  localparam int         OW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [NUM_W*N_REQ-1:0] req_num,
  input  logic                   lock,
  output logic [N_REQ-1:0]       grant,
  output logic [OW-1:0]          owner,
  output logic [NUM_W-1:0]       num,
  output logic                   scan_tick,
  output logic                   busy
);

  state_t             r_state;
  logic [N_REQ-1:0]   r_grant;
  logic [OW-1:0]      r_owner;
  logic [NUM_W-1:0]   r_num;
  logic [31:0]        r_dwell;

  logic [NUM_W-1:0]   w_slices [N_REQ];
  logic [NUM_W-1:0]   w_slice;
  logic [OW-1:0]      w_pick;
  logic               w_any;
  logic               w_own_req;
  logic               w_others;
  logic               w_expired;
  logic               w_scan_tick;

  // Nearest requester after 'last' wins; 'last' itself has lowest priority.
  function automatic logic [OW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                            input logic [OW-1:0]    last);
    logic [OW-1:0] pick;
    int            best;
    int            d;
    pick = last;
    best = N_REQ;
    for (int k = 0; k < N_REQ; k++) begin
      d = (k + 2 * N_REQ - int'(last) - 1) % N_REQ;
      if (r[k] && d < best) begin
        best = d;
        pick = OW'(k);
      end
    end
    return pick;
  endfunction

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign w_slices[gi] = req_num[NUM_W*gi +: NUM_W];
    end
  endgenerate

  // r_grant is the owner's one-hot mask whenever it matters (HOLD only).
  assign w_slice   = w_slices[r_owner];
  assign w_pick    = rr_pick(req, r_owner);
  assign w_any     = |req;
  assign w_own_req = |(req & r_grant);
  assign w_others  = |(req & ~r_grant);
  assign w_expired = (r_dwell == 32'(DWELL - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_owner <= OW'(N_REQ - 1);
      r_num   <= '0;
      r_dwell <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_grant <= '0;
          if (w_any) r_state <= ARB;
        end
        ARB: begin
          if (w_any) begin
            r_state <= HOLD;
            r_grant <= N_REQ'(1) << w_pick;
            r_owner <= w_pick;
            r_dwell <= '0;
          end else begin
            r_state <= IDLE;
            r_grant <= '0;
          end
        end
        HOLD: begin
          r_num <= w_slice;
          if (!lock) begin
            if (!w_own_req || (w_expired && w_others)) begin
              r_grant <= '0;
              r_state <= w_others ? ARB : IDLE;
            end else if (w_expired) begin
              r_dwell <= '0;
            end else begin
              r_dwell <= r_dwell + 32'd1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

  scan_prescaler #(
    .SCAN_DIV(SCAN_DIV)
  ) u_scan (
    .clk  (clk),
    .rst  (rst),
    .tick (w_scan_tick)
  );

  assign grant     = r_grant;
  assign owner     = r_owner;
  assign num       = r_num;
  assign scan_tick = w_scan_tick;
  assign busy      = (r_state != IDLE);

endmodule
